// File: rtl/hall_tick_conditioner.sv
// hall_tick_conditioner
//   Turns the raw hall-effect sensor (one magnet pass per rotor turn) into a
//   clean one-cycle turn_tick for angle_computer. The input is synchronised,
//   both edges are debounced, assertions that arrive sooner than
//   MIN_PERIOD_CYCLES after the previous accepted tick are rejected, the turn
//   period is measured in clk cycles, and a stalled rotor is flagged.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-low
//   hall_n        raw sensor pin, asynchronous; 0 = magnet present
//   turn_tick     one-cycle pulse per accepted turn
//   tick_rejected one-cycle pulse when a confirmed assertion comes too early
//   period        cycles between the last two accepted ticks
//   period_valid  period holds a measurement not interrupted by a stall
//   stalled       no accepted tick for STALL_CYCLES cycles, or none since reset
//   dbg_state     current debounce state (RELEASED/ARMING/ENGAGED/DISARMING)
//
// Output semantics: turn_tick and tick_rejected are single-cycle strobes with
// no back-pressure; a consumer must sample them every cycle. They are never
// high together. period/period_valid/stalled are levels that only change in
// the cycle a strobe or a stall is reported.

module hall_tick_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int MIN_PERIOD_CYCLES = 50000,
    parameter int STALL_CYCLES      = 5000000,
    parameter int COUNTER_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hall_n,
    output logic                     turn_tick,
    output logic                     tick_rejected,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid,
    output logic                     stalled,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        ENGAGED   = 2'd2,
        DISARMING = 2'd3
    } state_t;

    // The cycle that leaves RELEASED/ENGAGED already counts as the first
    // stable sample, so the ARMING/DISARMING counter only needs to reach
    // DEBOUNCE_CYCLES-2. With DEBOUNCE_CYCLES=1 the intermediate state still
    // lasts one cycle.
    localparam int DEB_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DEB_LAST_I = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [DEB_W-1:0]         DEB_LAST = DEB_W'(DEB_LAST_I);
    localparam logic [COUNTER_WIDTH-1:0] MIN_C    = COUNTER_WIDTH'(MIN_PERIOD_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] STALL_C  = COUNTER_WIDTH'(STALL_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     s;
    state_t                   state_q, state_d;
    logic [DEB_W-1:0]         deb_q, deb_d;
    logic                     confirm;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic                     first_q;
    logic                     stall_hit;

    // Synchroniser: resets to the idle (no magnet) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hall_n};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RELEASED;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
        end
    end

    // Debounce FSM next state. confirm marks the ARMING->ENGAGED step, which
    // is the only place a turn is evaluated.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        confirm = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = ARMING;
                    deb_d   = '0;
                end
            end
            ARMING: begin
                if (s) begin
                    state_d = RELEASED;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ENGAGED;
                    confirm = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            ENGAGED: begin
                if (s) begin
                    state_d = DISARMING;
                    deb_d   = '0;
                end
            end
            DISARMING: begin
                if (!s) begin
                    state_d = ENGAGED;
                end else if (deb_q == DEB_LAST) begin
                    state_d = RELEASED;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign dbg_state = state_q;

    // A stall can only be declared once a tick has been seen since the last
    // reset or stall; first_q=1 means the next confirmation starts afresh.
    assign stall_hit = !first_q && (cnt_q == STALL_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            first_q       <= 1'b1;
            period        <= '0;
            period_valid  <= 1'b0;
            stalled       <= 1'b1;
            turn_tick     <= 1'b0;
            tick_rejected <= 1'b0;
        end else begin
            turn_tick     <= 1'b0;
            tick_rejected <= 1'b0;
            cnt_q         <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNTER_WIDTH'(1);
            if (confirm) begin
                if (first_q || stall_hit) begin
                    // Start of a new measurement run; a stall landing in the
                    // same cycle still invalidates the old period.
                    turn_tick <= 1'b1;
                    cnt_q     <= COUNTER_WIDTH'(1);
                    first_q   <= 1'b0;
                    stalled   <= 1'b0;
                    if (stall_hit) begin
                        period_valid <= 1'b0;
                    end
                end else if (cnt_q >= MIN_C) begin
                    turn_tick    <= 1'b1;
                    period       <= cnt_q;
                    period_valid <= 1'b1;
                    cnt_q        <= COUNTER_WIDTH'(1);
                end else begin
                    tick_rejected <= 1'b1;
                end
            end else if (stall_hit) begin
                stalled      <= 1'b1;
                period_valid <= 1'b0;
                first_q      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hall_tick_conditioner.sv
// tb_hall_tick_conditioner
//   Self-checking bench for hall_tick_conditioner. A reference model samples
//   hall_n every rising edge, delays it through the synchroniser depth, and
//   confirms a level once the last DEBOUNCE_CYCLES samples agree; turn timing
//   is tracked as edge timestamps. Expected strobes and stall events go into
//   exp_q and a monitor compares them against the DUT as they appear.

module tb_hall_tick_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int MINP  = 50;
    localparam int STALL = 1000;
    localparam int CW    = 16;
    localparam int EW    = CW + 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [1:0] K_TICK  = 2'd1;
    localparam logic [1:0] K_REJ   = 2'd2;
    localparam logic [1:0] K_STALL = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic hall_n = 1'b1;

    always #5 clk = ~clk;

    logic          turn_tick;
    logic          tick_rejected;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          stalled;
    logic [1:0]    dbg_state;

    hall_tick_conditioner #(
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .MIN_PERIOD_CYCLES(MINP),
        .STALL_CYCLES     (STALL),
        .COUNTER_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_n       (hall_n),
        .turn_tick    (turn_tick),
        .tick_rejected(tick_rejected),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_ticks  = 0;
    int n_rej    = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic          s_pipe[$];
    logic          win[$];
    int            edge_n   = 0;
    int            last_acc = 0;
    bit            m_first  = 1'b1;
    logic          m_level  = 1'b1;
    logic [CW-1:0] m_period = '0;
    logic          m_pv     = 1'b0;
    logic          m_stall  = 1'b1;

    task automatic model_reset();
        s_pipe.delete();
        win.delete();
        for (int i = 0; i < SYNC; i++) s_pipe.push_back(1'b1);
        for (int i = 0; i < DEB; i++) win.push_back(1'b1);
        m_first  = 1'b1;
        m_level  = 1'b1;
        m_period = '0;
        m_pv     = 1'b0;
        m_stall  = 1'b1;
        // The counter holds 0 in reset and reads 0 at the first live edge.
        last_acc = edge_n + 1;
    endtask

    task automatic model_step();
        int   cnt_seen;
        logic s_now;
        bit   steady;
        bit   stall_now;
        bit   confirm_now;
        edge_n++;
        if (!rst) begin
            model_reset();
        end else begin
            cnt_seen = edge_n - last_acc;
            if (cnt_seen > CMAX) cnt_seen = CMAX;
            s_now = s_pipe.pop_front();
            s_pipe.push_back(hall_n);
            void'(win.pop_front());
            win.push_back(s_now);
            steady = 1'b1;
            foreach (win[i]) if (win[i] !== s_now) steady = 1'b0;
            stall_now   = !m_first && (cnt_seen == STALL);
            confirm_now = steady && (s_now !== m_level) && (s_now == 1'b0);
            if (steady) m_level = s_now;
            if (confirm_now) begin
                if (m_first || stall_now) begin
                    m_first  = 1'b0;
                    m_stall  = 1'b0;
                    if (stall_now) m_pv = 1'b0;
                    last_acc = edge_n;
                    exp_q.push_back({K_TICK, m_period, m_pv, m_stall});
                end else if (cnt_seen >= MINP) begin
                    m_period = CW'(cnt_seen);
                    m_pv     = 1'b1;
                    last_acc = edge_n;
                    exp_q.push_back({K_TICK, m_period, m_pv, m_stall});
                end else begin
                    exp_q.push_back({K_REJ, m_period, m_pv, m_stall});
                end
            end else if (stall_now) begin
                m_stall = 1'b1;
                m_pv    = 1'b0;
                m_first = 1'b1;
                exp_q.push_back({K_STALL, m_period, m_pv, m_stall});
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    logic prev_stalled = 1'b1;

    initial begin
        logic [1:0]    kind;
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stalled = 1'b1;
            end else begin
                if (turn_tick && tick_rejected) begin
                    check("tick_and_reject_together", 32'(1), 32'(0));
                end
                kind = 2'd0;
                if (turn_tick) kind = K_TICK;
                else if (tick_rejected) kind = K_REJ;
                else if (stalled && !prev_stalled) kind = K_STALL;
                if (turn_tick) n_ticks++;
                if (tick_rejected) n_rej++;
                if (kind != 2'd0) begin
                    got = {kind, period, period_valid, stalled};
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: got kind=%0d period=%0d pv=%0b stalled=%0b expected no event",
                                 kind, period, period_valid, stalled);
                    end else begin
                        exp = exp_q.pop_front();
                        check("event{kind,period,pv,stalled}", 32'(got), 32'(exp));
                    end
                end
                prev_stalled = stalled;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int low, input int high);
        hall_n = 1'b0;
        wait_cycles(low);
        hall_n = 1'b1;
        wait_cycles(high);
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic pv_at_tick;
        int r;

        // Reset held for 3 cycles.
        rst    = 1'b0;
        hall_n = 1'b1;
        wait_cycles(3);
        check("reset_turn_tick", 32'(turn_tick), 32'(0));
        check("reset_tick_rejected", 32'(tick_rejected), 32'(0));
        check("reset_period", 32'(period), 32'(0));
        check("reset_period_valid", 32'(period_valid), 32'(0));
        check("reset_stalled", 32'(stalled), 32'(1));
        check("reset_state", 32'(dbg_state), 32'(0));
        rst = 1'b1;
        wait_cycles(6);

        // Short glitch must not confirm.
        pulse(3, 10);
        check("glitch_no_tick", 32'(n_ticks), 32'(0));
        check("glitch_no_reject", 32'(n_rej), 32'(0));
        check("glitch_state_released", 32'(dbg_state), 32'(0));

        // First tick, then a 200-cycle turn.
        pulse(20, 180);
        pulse(20, 10);
        check("period_200", 32'(period), 32'(200));
        check("period_valid_200", 32'(period_valid), 32'(1));
        check("stalled_clear", 32'(stalled), 32'(0));

        // Early assertion (30 cycles) rejected, then 90 accepted.
        pulse(20, 40);
        check("reject_count", 32'(n_rej), 32'(1));
        check("period_kept_200", 32'(period), 32'(200));
        hall_n = 1'b0;
        wait_cycles(20);
        check("period_90", 32'(period), 32'(90));
        check("period_valid_90", 32'(period_valid), 32'(1));

        // No edges: stall after 1000 cycles, period retained.
        hall_n = 1'b1;
        wait_cycles(1100);
        check("stall_flag", 32'(stalled), 32'(1));
        check("stall_period_valid", 32'(period_valid), 32'(0));
        check("stall_period_kept", 32'(period), 32'(90));

        // Tick after stall: accepted as a first tick.
        r = n_ticks;
        pulse(20, 980);
        check("post_stall_tick", 32'(n_ticks - r), 32'(1));
        check("post_stall_period", 32'(period), 32'(90));
        check("post_stall_pv", 32'(period_valid), 32'(0));

        // Confirmation exactly at cnt==STALL: treated as a first tick.
        pulse(20, 30);
        check("coincident_stalled", 32'(stalled), 32'(0));
        check("coincident_pv", 32'(period_valid), 32'(0));
        check("coincident_period", 32'(period), 32'(90));

        // Exactly MIN_PERIOD accepted, one short of it rejected.
        r = n_rej;
        pulse(20, 29);
        check("min_period_accept", 32'(period), 32'(50));
        pulse(20, 60);
        check("min_minus_one_reject", 32'(n_rej - r), 32'(1));
        drain(50);

        // Randomised pulses, bounces and idle gaps.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pulse($urandom_range(1, 3), $urandom_range(5, 12));
            end else if (r < 4) begin
                hall_n = 1'b0;
                wait_cycles($urandom_range(5, 12));
                hall_n = 1'b1;
                wait_cycles($urandom_range(1, 3));
                pulse($urandom_range(5, 15), $urandom_range(10, 120));
            end else if (r == 4) begin
                pulse($urandom_range(5, 20), $urandom_range(990, 1010));
            end else begin
                pulse($urandom_range(4, 30), $urandom_range(10, 150));
            end
        end
        drain(50);

        // Reset mid-ARMING with hall_n held low.
        hall_n = 1'b0;
        wait_cycles(3);
        check("arming_before_reset", 32'(dbg_state), 32'(1));
        rst = 1'b0;
        #1;
        check("midreset_turn_tick", 32'(turn_tick), 32'(0));
        check("midreset_period", 32'(period), 32'(0));
        check("midreset_period_valid", 32'(period_valid), 32'(0));
        check("midreset_stalled", 32'(stalled), 32'(1));
        check("midreset_state", 32'(dbg_state), 32'(0));
        wait_cycles(2);
        rst = 1'b1;
        lat = -1;
        pv_at_tick = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (turn_tick) begin
                lat = i;
                pv_at_tick = period_valid;
                break;
            end
        end
        check("post_reset_tick_latency", 32'(lat), 32'(6));
        check("post_reset_tick_pv", 32'(pv_at_tick), 32'(0));
        hall_n = 1'b1;
        wait_cycles(20);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
